cpu_image_loader: RTL and testbench

Boot and run sequencer for the single-cycle MIPS core (`Simple_Single_CPU`). It takes the instruction image and then the data image as one 32-bit word stream over a valid/ready handshake. It writes the instruction and data memories byte by byte in big-endian order, zero-fills the rest of data memory, and loads PC and $sp. It then enables the CPU, counts cycles, and stops the CPU on a halt instruction (opcode 0x3f) or on a memory error.

---
 rtl/cpu_image_loader.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cpu_image_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_image_loader.sv
// Boot/run sequencer for Simple_Single_CPU: streams the instruction and data images into
// byte-wide memories, loads PC and $sp, then runs the core until halt or a memory error.
module cpu_image_loader #(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter int unsigned DMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  output logic        im_we_o,
  output logic [31:0] im_addr_o,
  output logic [7:0]  im_wdata_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [7:0]  dm_wdata_o,
  output logic        pc_we_o,
  output logic        sp_we_o,
  output logic [31:0] init_o,
  output logic        cpu_run_o,
  input  logic        halt_i,
  input  logic        addr_ovf_i,
  input  logic        misalign_i,
  output logic [31:0] cycle_o,
  output logic        done_o,
  output logic [1:0]  status_o
);

  typedef enum logic [3:0] {
    S_IPC, S_ICNT, S_IWORD, S_IBYTE, S_DSP, S_DCNT,
    S_DWORD, S_DBYTE, S_DFILL, S_RUN, S_DONE
  } state_e;

  localparam logic [34:0] IMEM_LIM  = 35'(IMEM_BYTES);
  localparam logic [33:0] DMEM_LIM  = 34'(DMEM_BYTES);
  localparam logic [31:0] DMEM_SZ   = 32'(DMEM_BYTES);
  localparam logic [31:0] DMEM_LAST = 32'(DMEM_BYTES - 1);

  state_e      state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] fill_q, fill_d;
  logic [31:0] cycle_q, cycle_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  status_q, status_d;

  logic        ready_q, ready_d;
  logic        im_we_q, im_we_d;
  logic [31:0] im_addr_q, im_addr_d;
  logic [7:0]  im_wdata_q, im_wdata_d;
  logic        dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [7:0]  dm_wdata_q, dm_wdata_d;
  logic        pc_we_q, pc_we_d;
  logic        sp_we_q, sp_we_d;
  logic [31:0] init_q, init_d;
  logic        run_q, run_d;
  logic        done_q, done_d;

  logic        hs;
  logic [34:0] im_end;
  logic [33:0] dm_len;
  logic [31:0] idx_inc;
  logic [31:0] fill_start;
  logic [7:0]  byte_sel;

  assign hs         = s_valid_i && ready_q;
  assign im_end     = {3'b000, base_q} + {1'b0, s_data_i, 2'b00};
  assign dm_len     = {s_data_i, 2'b00};
  assign idx_inc    = idx_q + 32'd1;
  assign fill_start = {cnt_q[29:0], 2'b00};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    word_d   = word_q;
    fill_d   = fill_q;
    cycle_d  = cycle_q;
    k_d      = k_q;
    status_d = status_q;
    pc_we_d  = 1'b0;
    sp_we_d  = 1'b0;
    init_d   = '0;
    unique case (state_q)
      S_IPC: if (hs) begin
        pc_we_d = 1'b1;
        init_d  = s_data_i;
        base_d  = s_data_i;
        state_d = S_ICNT;
      end
      S_ICNT: if (hs) begin
        cnt_d = s_data_i;
        idx_d = '0;
        if (im_end > IMEM_LIM) begin
          state_d  = S_DONE;
          status_d = 2'b11;
        end else if (s_data_i == '0) begin
          state_d = S_DSP;
        end else begin
          state_d = S_IWORD;
        end
      end
      S_IWORD: if (hs) begin
        word_d  = s_data_i;
        k_d     = '0;
        state_d = S_IBYTE;
      end
      S_IBYTE: begin
        if (k_q == 2'd3) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == cnt_q) ? S_DSP : S_IWORD;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DSP: if (hs) begin
        sp_we_d = 1'b1;
        init_d  = s_data_i;
        state_d = S_DCNT;
      end
      S_DCNT: if (hs) begin
        cnt_d = s_data_i;
        idx_d = '0;
        if (dm_len > DMEM_LIM) begin
          state_d  = S_DONE;
          status_d = 2'b11;
        end else if (s_data_i == '0) begin
          fill_d  = '0;
          state_d = (DMEM_SZ == '0) ? S_RUN : S_DFILL;
        end else begin
          state_d = S_DWORD;
        end
      end
      S_DWORD: if (hs) begin
        word_d  = s_data_i;
        k_d     = '0;
        state_d = S_DBYTE;
      end
      S_DBYTE: begin
        if (k_q == 2'd3) begin
          idx_d = idx_inc;
          if (idx_inc == cnt_q) begin
            fill_d  = fill_start;
            state_d = (fill_start == DMEM_SZ) ? S_RUN : S_DFILL;
          end else begin
            state_d = S_DWORD;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DFILL: begin
        if (fill_q == DMEM_LAST) state_d = S_RUN;
        else                     fill_d  = fill_q + 32'd1;
      end
      S_RUN: begin
        cycle_d = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
        if (halt_i || addr_ovf_i || misalign_i) begin
          state_d  = S_DONE;
          status_d = (addr_ovf_i || misalign_i) ? 2'b10 : 2'b01;
        end
      end
      S_DONE: ;
      default: state_d = S_DONE;
    endcase
  end

  // Outputs are decoded from the next state so each registered strobe lines up with
  // the cycle in which its state is current.
  always_comb begin
    byte_sel = '0;
    unique case (k_d)
      2'd0: byte_sel = word_d[31:24];
      2'd1: byte_sel = word_d[23:16];
      2'd2: byte_sel = word_d[15:8];
      2'd3: byte_sel = word_d[7:0];
      default: byte_sel = '0;
    endcase
    ready_d    = state_d inside {S_IPC, S_ICNT, S_IWORD, S_DSP, S_DCNT, S_DWORD};
    im_we_d    = (state_d == S_IBYTE);
    im_addr_d  = '0;
    im_wdata_d = '0;
    if (im_we_d) begin
      im_addr_d  = base_d + {idx_d[29:0], 2'b00} + {30'b0, k_d};
      im_wdata_d = byte_sel;
    end
    dm_we_d    = (state_d == S_DBYTE) || (state_d == S_DFILL);
    dm_addr_d  = '0;
    dm_wdata_d = '0;
    if (state_d == S_DBYTE) begin
      dm_addr_d  = {idx_d[29:0], 2'b00} + {30'b0, k_d};
      dm_wdata_d = byte_sel;
    end else if (state_d == S_DFILL) begin
      dm_addr_d = fill_d;
    end
    run_d  = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IPC;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      fill_q     <= '0;
      cycle_q    <= '0;
      k_q        <= '0;
      status_q   <= '0;
      ready_q    <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      pc_we_q    <= 1'b0;
      sp_we_q    <= 1'b0;
      init_q     <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      fill_q     <= fill_d;
      cycle_q    <= cycle_d;
      k_q        <= k_d;
      status_q   <= status_d;
      ready_q    <= ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      pc_we_q    <= pc_we_d;
      sp_we_q    <= sp_we_d;
      init_q     <= init_d;
      run_q      <= run_d;
      done_q     <= done_d;
    end
  end

  assign s_ready_o  = ready_q;
  assign im_we_o    = im_we_q;
  assign im_addr_o  = im_addr_q;
  assign im_wdata_o = im_wdata_q;
  assign dm_we_o    = dm_we_q;
  assign dm_addr_o  = dm_addr_q;
  assign dm_wdata_o = dm_wdata_q;
  assign pc_we_o    = pc_we_q;
  assign sp_we_o    = sp_we_q;
  assign init_o     = init_q;
  assign cpu_run_o  = run_q;
  assign cycle_o    = cycle_q;
  assign done_o     = done_q;
  assign status_o   = status_q;

endmodule

// File: tb/tb_cpu_image_loader.sv
// Directed bench for cpu_image_loader: load timing, byte order, halt/error exit,
// image format error, backpressure and reset recovery.
module tb_cpu_image_loader;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic        im_we_o;
  logic [31:0] im_addr_o;
  logic [7:0]  im_wdata_o;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [7:0]  dm_wdata_o;
  logic        pc_we_o;
  logic        sp_we_o;
  logic [31:0] init_o;
  logic        cpu_run_o;
  logic        halt_i;
  logic        addr_ovf_i;
  logic        misalign_i;
  logic [31:0] cycle_o;
  logic        done_o;
  logic [1:0]  status_o;

  cpu_image_loader #(.IMEM_BYTES(1024), .DMEM_BYTES(1024)) dut (
    .clk_i(clk), .rst_i(rst_i), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o), .im_we_o(im_we_o), .im_addr_o(im_addr_o),
    .im_wdata_o(im_wdata_o), .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o),
    .dm_wdata_o(dm_wdata_o), .pc_we_o(pc_we_o), .sp_we_o(sp_we_o),
    .init_o(init_o), .cpu_run_o(cpu_run_o), .halt_i(halt_i),
    .addr_ovf_i(addr_ovf_i), .misalign_i(misalign_i), .cycle_o(cycle_o),
    .done_o(done_o), .status_o(status_o)
  );

  always #5 clk = ~clk;

  int unsigned tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned hs_start = 0;
  bit          first_pending = 1'b0;

  // Write monitor: memory model, write log and strobe-rule violations.
  logic        mon_clr = 1'b1;
  logic [7:0]  im_mem [0:1023];
  logic [31:0] dm_log_addr [0:2047];
  logic [7:0]  dm_log_data [0:2047];
  int unsigned im_cnt, dm_cnt, pc_cnt, sp_cnt, run_cnt, viol = 0;
  logic [31:0] pc_val, sp_val;

  always @(negedge clk) begin
    if (mon_clr) begin
      im_cnt = 0; dm_cnt = 0; pc_cnt = 0; sp_cnt = 0; run_cnt = 0;
      pc_val = 'x; sp_val = 'x;
      for (int i = 0; i < 1024; i++) im_mem[i] = 'x;
    end else begin
      if (im_we_o) begin
        im_mem[im_addr_o[9:0]] = im_wdata_o;
        im_cnt++;
      end
      if (dm_we_o) begin
        if (dm_cnt < 2048) begin
          dm_log_addr[dm_cnt] = dm_addr_o;
          dm_log_data[dm_cnt] = dm_wdata_o;
        end
        dm_cnt++;
      end
      if (pc_we_o) begin pc_cnt++; pc_val = init_o; end
      if (sp_we_o) begin sp_cnt++; sp_val = init_o; end
      if (cpu_run_o) run_cnt++;
    end
    if (im_we_o && dm_we_o) viol++;
    if (!im_we_o && (im_addr_o != 0 || im_wdata_o != 0)) viol++;
    if (!dm_we_o && (dm_addr_o != 0 || dm_wdata_o != 0)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    int unsigned n = 0;
    s_data_i  = w;
    s_valid_i = 1'b1;
    while (!s_ready_o && n < 3000) begin step(); n++; end
    if (!s_ready_o) chk("ready_timeout", {31'b0, s_ready_o}, 32'd1);
    if (first_pending) begin hs_start = tb_cyc; first_pending = 1'b0; end
    step();
  endtask

  task automatic wait_run(input int unsigned exp_cycles);
    int unsigned n = 0;
    while (!cpu_run_o && n < 3000) begin step(); n++; end
    chk("run_seen", {31'b0, cpu_run_o}, 32'd1);
    chk("load_cycles", tb_cyc - hs_start, exp_cycles);
    chk("cycle_first_run", cycle_o, 32'd0);
  endtask

  task automatic check_im(input logic [63:0] be, input int unsigned nb);
    int unsigned bad = 0;
    for (int unsigned i = 0; i < nb; i++)
      if (im_mem[i] !== be[63 - 8*i -: 8]) bad++;
    chk("im_bytes_bad", bad, 32'd0);
    chk("im_wr_cnt", im_cnt, nb);
  endtask

  task automatic check_dm(input logic [63:0] be, input int unsigned nb);
    int unsigned bad = 0;
    logic [7:0] exp_d;
    for (int unsigned i = 0; i < 1024; i++) begin
      exp_d = (i < nb) ? be[63 - 8*i -: 8] : 8'h00;
      if (dm_log_addr[i] !== i || dm_log_data[i] !== exp_d) bad++;
    end
    chk("dm_seq_bad", bad, 32'd0);
    chk("dm_wr_cnt", dm_cnt, 32'd1024);
  endtask

  task automatic clear_monitor();
    mon_clr = 1'b1;
    step();
    mon_clr = 1'b0;
  endtask

  task automatic nominal_load();
    first_pending = 1'b1;
    send_word(32'h0000_0000);
    chk("pc_we_pulse", {31'b0, pc_we_o}, 32'd1);
    chk("pc_init", init_o, 32'h0000_0000);
    send_word(32'd2);
    chk("pc_we_one_cycle", {31'b0, pc_we_o}, 32'd0);
    send_word(32'h8C01_0000);
    send_word(32'hFC00_0000);
    send_word(32'h0000_0400);
    chk("sp_init", init_o, 32'h0000_0400);
    send_word(32'd1);
    send_word(32'h1234_5678);
    s_valid_i = 1'b0;
    wait_run(1039);
    check_im(64'h8C01_0000_FC00_0000, 8);
    check_dm(64'h1234_5678_0000_0000, 4);
    chk("pc_we_cnt", pc_cnt, 32'd1);
    chk("pc_val", pc_val, 32'h0);
    chk("sp_we_cnt", sp_cnt, 32'd1);
    chk("sp_val", sp_val, 32'h400);
  endtask

  initial begin
    rst_i = 1'b1; s_valid_i = 1'b0; s_data_i = '0;
    halt_i = 1'b0; addr_ovf_i = 1'b0; misalign_i = 1'b0;
    step(); step(); step();

    // Reset values
    chk("rst_ready", {31'b0, s_ready_o}, 32'd0);
    chk("rst_im_we", {31'b0, im_we_o}, 32'd0);
    chk("rst_dm_we", {31'b0, dm_we_o}, 32'd0);
    chk("rst_init", init_o, 32'd0);
    chk("rst_run", {31'b0, cpu_run_o}, 32'd0);
    chk("rst_cycle", cycle_o, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_status", {30'b0, status_o}, 32'd0);
    rst_i = 1'b0;
    mon_clr = 1'b0;
    step();
    chk("ipc_ready", {31'b0, s_ready_o}, 32'd1);

    // Nominal image, then halt on the 3rd RUN cycle
    nominal_load();
    step();
    step();
    chk("run_cycle_2", cycle_o, 32'd2);
    halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    chk("halt_cycle", cycle_o, 32'd3);
    chk("halt_done", {31'b0, done_o}, 32'd1);
    chk("halt_run", {31'b0, cpu_run_o}, 32'd0);
    chk("halt_status", {30'b0, status_o}, 32'd1);
    step(); step(); step();
    chk("done_cycle_frozen", cycle_o, 32'd3);
    chk("done_sticky", {31'b0, done_o}, 32'd1);
    chk("done_ready", {31'b0, s_ready_o}, 32'd0);

    // Reset in the middle of an instruction byte burst
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    send_word(32'h0000_0000);
    send_word(32'd2);
    send_word(32'h8C01_0000);
    chk("byte0_we", {31'b0, im_we_o}, 32'd1);
    chk("byte0_data", {24'b0, im_wdata_o}, 32'h8C);
    step();
    chk("byte1_addr", im_addr_o, 32'd1);
    step();
    chk("byte2_addr", im_addr_o, 32'd2);
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    step();
    chk("midrst_im_we", {31'b0, im_we_o}, 32'd0);
    chk("midrst_im_addr", im_addr_o, 32'd0);
    rst_i = 1'b0;
    step();
    chk("midrst_ready", {31'b0, s_ready_o}, 32'd1);
    chk("midrst_im_we2", {31'b0, im_we_o}, 32'd0);
    clear_monitor();
    nominal_load();

    // Reset in the middle of RUN
    step(); step();
    rst_i = 1'b1;
    step();
    chk("runrst_run", {31'b0, cpu_run_o}, 32'd0);
    chk("runrst_cycle", cycle_o, 32'd0);
    chk("runrst_done", {31'b0, done_o}, 32'd0);
    rst_i = 1'b0;
    step();
    clear_monitor();

    // Backpressure: 7 idle cycles between the two data words
    first_pending = 1'b1;
    send_word(32'h0000_0000);
    send_word(32'd1);
    send_word(32'hFC00_0000);
    send_word(32'h0000_03FC);
    send_word(32'd2);
    send_word(32'hA1B2_C3D4);
    s_valid_i = 1'b0;
    for (int unsigned n = 0; n < 100 && !s_ready_o; n++) step();
    for (int unsigned g = 0; g < 7; g++) begin
      chk("gap_no_dm_we", {31'b0, dm_we_o}, 32'd0);
      step();
    end
    chk("gap_ready_held", {31'b0, s_ready_o}, 32'd1);
    send_word(32'h0F1E_2D3C);
    s_valid_i = 1'b0;
    wait_run(1042);
    check_im(64'hFC00_0000_0000_0000, 4);
    check_dm(64'hA1B2_C3D4_0F1E_2D3C, 8);
    chk("bp_sp_val", sp_val, 32'h3FC);

    // Halt and misalign together: error wins
    halt_i = 1'b1;
    misalign_i = 1'b1;
    step();
    halt_i = 1'b0;
    misalign_i = 1'b0;
    chk("err_status", {30'b0, status_o}, 32'd2);
    chk("err_cycle", cycle_o, 32'd1);
    chk("err_done", {31'b0, done_o}, 32'd1);
    chk("err_run", {31'b0, cpu_run_o}, 32'd0);

    // Image format error: 0x3F8 + 12 exceeds instruction memory
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    step();
    clear_monitor();
    send_word(32'h0000_03F8);
    send_word(32'd3);
    s_valid_i = 1'b0;
    chk("fmt_done", {31'b0, done_o}, 32'd1);
    chk("fmt_status", {30'b0, status_o}, 32'd3);
    chk("fmt_ready", {31'b0, s_ready_o}, 32'd0);
    for (int unsigned n = 0; n < 10; n++) step();
    chk("fmt_no_im_we", im_cnt, 32'd0);
    chk("fmt_no_run", run_cnt, 32'd0);

    chk("strobe_rules", viol, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
